// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_if
// Description : FIFO read-port bundle between MyFIFO and its UART drain stage.
// Revision    : 1.0
// ============================================================================
interface fifo_uart_tx_if #(
    parameter int BIT_DEPTH = 8
);
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [BIT_DEPTH-1:0] fifo_data;

    // master = the reader (UART drain), slave = the FIFO
    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops words from a FIFO and serialises them as start/data/stop UART.
// Revision    : 1.0
// ============================================================================
module fifo_uart_tx #(
    parameter int BIT_DEPTH    = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  wire              clk,
    input  wire              rst,
    fifo_uart_tx_if.master   fifo,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(BIT_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t               r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit;
    logic [BIT_DEPTH-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_rd_en;

    state_t               w_state_nxt;
    logic [BAUD_W-1:0]    w_baud_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [BIT_DEPTH-1:0] w_shift_nxt;
    logic                 w_tx_nxt;
    logic                 w_busy_nxt;
    logic                 w_frame_done_nxt;
    logic                 w_rd_en_nxt;
    logic                 w_wrap;
    logic                 w_serial;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_en      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_baud       <= w_baud_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_rd_en      <= w_rd_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_nxt        = r_bit;
        w_baud_nxt       = '0;
        w_tx_nxt         = 1'b1;
        w_busy_nxt       = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_rd_en_nxt      = 1'b0;
        w_wrap           = (r_baud == c_baud_last);
        w_serial         = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

        case (r_state)
            S_IDLE:  if (!fifo.fifo_empty) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                // FIFO output has settled one cycle after the read strobe
                w_shift_nxt = fifo.fifo_data;
                w_state_nxt = S_START;
            end
            S_START: if (w_wrap) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_wrap) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == c_bit_last) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            S_STOP:  if (w_wrap) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_serial && !w_wrap && (w_state_nxt == r_state))
            w_baud_nxt = r_baud + 1'b1;

        // Outputs are decoded from the next state so the registers line up with the state
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_rd_en_nxt      = (w_state_nxt == S_READ);
        w_frame_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == c_baud_last);
    end

    assign tx              = r_tx;
    assign busy            = r_busy;
    assign frame_done      = r_frame_done;
    assign fifo.fifo_rd_en = r_rd_en;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Directed self-checking bench for fifo_uart_tx (8 data bits, 4 clks/bit).
// Revision    : 1.0
// ============================================================================
module tb_fifo_uart_tx;
    logic clk;
    logic rst;
    logic tx;
    logic busy;
    logic frame_done;

    int tests = 0;
    int fails = 0;
    int rd_pulses = 0;
    int frame_dones = 0;
    logic [7:0] q[$];

    fifo_uart_tx_if #(.BIT_DEPTH(8)) ff ();

    fifo_uart_tx #(.BIT_DEPTH(8), .CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo       (ff.master),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge and model the FIFO read port there
    task automatic cyc();
        @(negedge clk);
        if (ff.fifo_rd_en === 1'b1) begin
            rd_pulses++;
            if (q.size() > 0) ff.fifo_data = q.pop_front();
        end
        ff.fifo_empty = (q.size() == 0);
        if (frame_done === 1'b1) frame_dones++;
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        ff.fifo_empty = 1'b0;
    endtask

    task automatic wait_low(output int n);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    // Called with tx already seen low on the first start-bit cycle
    task automatic capture(input logic [7:0] exp_byte, input int corrupt_at,
                           output logic [7:0] b, output int bad, output int fd_idx,
                           output logic busy_end);
        logic s [40];
        logic e;
        bad = 0;
        fd_idx = -1;
        s[0] = tx;
        for (int i = 1; i < 40; i++) begin
            cyc();
            if (i == corrupt_at) ff.fifo_data = 8'h00;
            s[i] = tx;
            if (frame_done === 1'b1) fd_idx = i;
        end
        busy_end = busy;
        for (int i = 0; i < 40; i++) begin
            e = (i < 4) ? 1'b0 : (i < 36) ? exp_byte[(i - 4) / 4] : 1'b1;
            if (s[i] !== e) bad++;
        end
        for (int k = 0; k < 8; k++) b[k] = s[4 + 4 * k + 2];
    endtask

    initial begin
        int n, bad, fdi, rd0, fd0;
        logic [7:0] b;
        logic bz;

        rst = 1'b0;
        ff.fifo_empty = 1'b1;
        ff.fifo_data = 8'h00;
        repeat (3) cyc();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", ff.fifo_rd_en, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b1;
        repeat (2) cyc();

        // Single word A5
        rd0 = rd_pulses; fd0 = frame_dones;
        push(8'hA5);
        wait_low(n);
        chk("a5_latency", n, 3);
        capture(8'hA5, -1, b, bad, fdi, bz);
        chk("a5_shape", bad, 0);
        chk("a5_byte", b, 8'hA5);
        chk("a5_fd_idx", fdi, 39);
        chk("a5_busy_stop", bz, 1);
        cyc();
        chk("a5_busy_after", busy, 0);
        chk("a5_rd_pulses", rd_pulses - rd0, 1);
        chk("a5_fd_count", frame_dones - fd0, 1);

        // Back-to-back 07, 0C
        rd0 = rd_pulses;
        push(8'h07);
        push(8'h0C);
        wait_low(n);
        chk("b2b_latency", n, 3);
        capture(8'h07, -1, b, bad, fdi, bz);
        chk("b2b_shape0", bad, 0);
        chk("b2b_byte0", b, 8'h07);
        wait_low(n);
        chk("b2b_gap", n, 4);
        capture(8'h0C, -1, b, bad, fdi, bz);
        chk("b2b_shape1", bad, 0);
        chk("b2b_byte1", b, 8'h0C);
        repeat (3) cyc();
        chk("b2b_rd_pulses", rd_pulses - rd0, 2);
        chk("b2b_busy_end", busy, 0);
        chk("b2b_tx_end", tx, 1);

        // Empty FIFO for 200 cycles
        rd0 = rd_pulses;
        bad = 0;
        repeat (200) begin
            cyc();
            if (tx !== 1'b1 || busy !== 1'b0 || ff.fifo_rd_en !== 1'b0) bad++;
        end
        chk("idle_bad", bad, 0);
        chk("idle_rd_pulses", rd_pulses - rd0, 0);

        // Asynchronous reset while the read strobe is high
        push(8'h11);
        cyc();
        chk("pre_rst_rd_en", ff.fifo_rd_en, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rd_en", ff.fifo_rd_en, 0);
        cyc();
        rst = 1'b1;
        rd0 = rd_pulses;
        repeat (5) cyc();
        chk("post_rst_no_read", rd_pulses - rd0, 0);

        // Reset during bit 3 of FF; the next frame must carry 5A
        push(8'hFF);
        push(8'h5A);
        wait_low(n);
        repeat (4 + 4 * 3 + 1) cyc();
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        cyc();
        cyc();
        rst = 1'b1;
        wait_low(n);
        chk("mid_rst_latency", n, 3);
        capture(8'h5A, -1, b, bad, fdi, bz);
        chk("mid_rst_shape", bad, 0);
        chk("mid_rst_byte", b, 8'h5A);

        // FIFO output changes during DATA of 3C
        push(8'h3C);
        wait_low(n);
        capture(8'h3C, 10, b, bad, fdi, bz);
        chk("immune_shape", bad, 0);
        chk("immune_byte", b, 8'h3C);
        chk("immune_fd_idx", fdi, 39);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
